// File: rtl/stage_fetch_q.sv
// Instruction-fetch stage: one outstanding imem request at a time, with fetched
// {instr, pc} pairs buffered in a small FIFO ahead of decode. A redirect flushes it all.
module stage_fetch_q #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4
);

    localparam int unsigned      PTR_W   = $clog2(QDEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic [31:0]      q_instr [QDEPTH];
    logic [XLEN-1:0]  q_pc    [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic credit;
    logic issue_slot;
    logic req_fire;
    logic push;
    logic pop;

    logic unused_addr_bits;
    assign unused_addr_bits = ^redirect_addr[1:0];

    // In WAIT the outstanding response still needs a slot, so one more must be free.
    always_comb begin
        credit     = 1'b0;
        issue_slot = 1'b0;
        case (state)
            ST_IDLE: begin
                credit     = (count < DEPTH_C);
                issue_slot = 1'b1;
            end
            ST_WAIT: begin
                credit     = ((count + CNT_W'(1)) < DEPTH_C);
                issue_slot = imem_rsp_valid;
            end
            ST_DROP: begin
                credit     = (count < DEPTH_C);
                issue_slot = imem_rsp_valid;
            end
            default: begin
                credit     = 1'b0;
                issue_slot = 1'b0;
            end
        endcase
    end

    assign imem_req_valid = !rst && !redirect_valid && credit && issue_slot;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop            = out_valid && out_ready;

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = (state != ST_IDLE && !imem_rsp_valid) ? ST_DROP : ST_IDLE;
        end else if (req_fire) begin
            state_next = ST_WAIT;
        end else if (state != ST_IDLE && imem_rsp_valid) begin
            state_next = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fetch_pc <= {redirect_addr[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage is reset so the head outputs read as zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]    <= req_pc;
        end
    end

    assign out_valid = (count != '0);
    assign out_instr = q_instr[rd_ptr];
    assign out_pc    = q_pc[rd_ptr];
    assign out_pc4   = out_pc + XLEN'(4);

endmodule

// File: tb/tb_stage_fetch_q.sv
// Bench for stage_fetch_q: variable-latency memory model, scoreboard of expected
// {pc, instr} pairs, and one task per scenario. A second instance covers PC wrap-around.
`timescale 1ns/1ps
module tb_stage_fetch_q;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_pc4;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] sb_e;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h0000_0013;
    endfunction

    stage_fetch_q #(.XLEN(32), .RESET_PC(32'h0000_0100), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
    );

    stage_fetch_q #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut_w (
        .clk(clk), .rst(rst),
        .redirect_valid(1'b0), .redirect_addr(32'h0),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .out_pc4(w_out_pc4)
    );

    // Memory for the main instance: fixed latency, ignores the fetch stage's reset.
    int          mem_lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_timer = 0;
    logic [31:0] mem_addr = '0;

    assign rsp_valid = mem_busy && (mem_timer == 0);
    assign rsp_data  = rsp_valid ? instr_of(mem_addr) : 32'h0;

    always @(posedge clk) begin
        if (rsp_valid) mem_busy <= 1'b0;
        if (req_valid && req_ready) begin
            mem_busy  <= 1'b1;
            mem_addr  <= req_addr;
            mem_timer <= mem_lat - 1;
        end else if (mem_busy && mem_timer > 0) begin
            mem_timer <= mem_timer - 1;
        end
    end

    logic        w_busy = 1'b0;
    logic [31:0] w_addr = '0;
    assign w_rsp_valid = w_busy;
    assign w_rsp_data  = w_busy ? instr_of(w_addr) : 32'h0;

    always @(posedge clk) begin
        if (w_rsp_valid) w_busy <= 1'b0;
        if (w_req_valid) begin
            w_busy <= 1'b1;
            w_addr <= w_req_addr;
        end
    end

    // Scoreboard: accepted requests are expected in order unless a redirect squashes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no output", out_pc, out_instr);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (out_pc !== sb_e[63:32] || out_instr !== sb_e[31:0] || out_pc4 !== sb_e[63:32] + 32'd4) begin
                        errors++;
                        $display("FAIL sb_entry: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                                 out_pc, out_instr, out_pc4, sb_e[63:32], sb_e[31:0], sb_e[63:32] + 32'd4);
                    end
                end
            end
            if (redirect_valid) exp_q.delete();
            else if (req_valid && req_ready) exp_q.push_back({req_addr, instr_of(req_addr)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat, input logic ordy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        req_ready      = 1'b1;
        out_ready      = ordy;
        mem_lat        = lat;
        repeat (5) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || req_valid !== 1'b0 || req_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_ctrl: got out_valid=%b req_valid=%b req_addr=%h, expected 0 0 00000100",
                     out_valid, req_valid, req_addr);
        end
        checks++;
        if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_head: got instr=%h pc=%h pc4=%h, expected 0 0 4", out_instr, out_pc, out_pc4);
        end
        checks++;
        if (w_req_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL reset_wrap_addr: got %h, expected fffffff8", w_req_addr);
        end
    endtask

    task automatic test_reset_vector();
        logic stream_ok = 1'b1;
        do_reset(1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if (req_valid !== 1'b1 || req_addr !== 32'h100 + 32'(4 * c)) begin
                    errors++;
                    $display("FAIL vec_req%0d: got valid=%b addr=%h, expected 1 %h", c, req_valid, req_addr, 32'h100 + 32'(4 * c));
                end
            end
            if (c == 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL vec_early_out: got out_valid=%b, expected 0", out_valid);
                end
            end
            if (c == 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
                    errors++;
                    $display("FAIL vec_first_out: got valid=%b pc=%h, expected 1 00000100", out_valid, out_pc);
                end
            end
            if (c >= 2 && out_valid !== 1'b1) stream_ok = 1'b0;
            step();
        end
        checks++;
        if (stream_ok !== 1'b1) begin
            errors++;
            $display("FAIL vec_throughput: got a bubble in out_valid, expected one entry per cycle");
        end
    endtask

    task automatic test_backpressure();
        int   n_acc = 0;
        logic stable = 1'b1;
        logic found = 1'b0;
        do_reset(1, 1'b0);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) n_acc++;
            if (c >= 2 && out_pc !== 32'h100) stable = 1'b0;
            step();
        end
        @(negedge clk);
        checks++;
        if (n_acc != 4 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: got %0d accepts, req_valid=%b, expected 4 accepts and 0", n_acc, req_valid);
        end
        checks++;
        if (stable !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: got pc=%h valid=%b with a change during stall, expected 00000100 held", out_pc, out_valid);
        end
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                found = 1'b1;
                checks++;
                if (req_addr !== 32'h110) begin
                    errors++;
                    $display("FAIL bp_resume: got addr=%h, expected 00000110", req_addr);
                end
            end
            step();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL bp_resume_timeout: got no request, expected one at 00000110");
        end
        repeat (8) step();
    endtask

    task automatic wait_first_out(input string name, input logic [31:0] pc);
        logic found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                checks++;
                if (out_pc !== pc || out_instr !== instr_of(pc)) begin
                    errors++;
                    $display("FAIL %s: got pc=%h instr=%h, expected %h %h", name, out_pc, out_instr, pc, instr_of(pc));
                end
            end
            step();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid, expected pc=%h", name, pc);
        end
    endtask

    task automatic test_squash();
        do_reset(3, 1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h2002;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL sq_redirect_cycle: got req_valid=%b, expected 0", req_valid);
        end
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL sq_drop_wait: got req_valid=%b, expected 0", req_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (!(rsp_valid && req_valid === 1'b1 && req_addr === 32'h2000)) begin
            errors++;
            $display("FAIL sq_reissue: got rsp=%b req_valid=%b addr=%h, expected 1 1 00002000", rsp_valid, req_valid, req_addr);
        end
        step();
        wait_first_out("sq_first_out", 32'h2000);
    endtask

    task automatic test_redirect_rsp();
        do_reset(1, 1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_no_req: got req_valid=%b, expected 0", req_valid);
        end
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h40) begin
            errors++;
            $display("FAIL rr_next: got out_valid=%b req_valid=%b addr=%h, expected 0 1 00000040", out_valid, req_valid, req_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_empty: got out_valid=%b, expected 0", out_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
            errors++;
            $display("FAIL rr_out: got valid=%b pc=%h, expected 1 00000040", out_valid, out_pc);
        end
        repeat (4) step();
    endtask

    task automatic test_back_to_back();
        do_reset(3, 1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h300;
        step();
        redirect_addr  = 32'h400;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: got req_valid=%b, expected 0", req_valid);
        end
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h400) begin
            errors++;
            $display("FAIL b2b_target: got valid=%b addr=%h, expected 1 00000400", req_valid, req_addr);
        end
        step();
        wait_first_out("b2b_first_out", 32'h400);
    endtask

    task automatic test_async_reset();
        int n_acc = 0;
        do_reset(3, 1'b0);
        for (int c = 0; c < 30 && n_acc < 4; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) n_acc++;
            step();
        end
        @(negedge clk);
        checks++;
        if (n_acc != 4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_setup: got %0d accepts valid=%b, expected 4 1", n_acc, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_valid !== 1'b0 || req_addr !== 32'h100 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL ar_immediate: got valid=%b req=%b addr=%h pc=%h, expected 0 0 00000100 0",
                     out_valid, req_valid, req_addr, out_pc);
        end
        exp_q.delete();
        req_ready = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
            errors++;
            $display("FAIL ar_restart: got valid=%b addr=%h, expected 1 00000100", req_valid, req_addr);
        end
        repeat (3) step();
        req_ready = 1'b1;
        out_ready = 1'b1;
        wait_first_out("ar_first_out", 32'h100);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        int k = 0;
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset(1, 1'b1);
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clk);
            if (w_out_valid) begin
                checks++;
                if (w_out_pc !== exp_pc[k] || w_out_pc4 !== exp_pc[k] + 32'd4 || w_out_instr !== instr_of(exp_pc[k])) begin
                    errors++;
                    $display("FAIL wrap_entry%0d: got pc=%h pc4=%h instr=%h, expected %h %h %h", k,
                             w_out_pc, w_out_pc4, w_out_instr, exp_pc[k], exp_pc[k] + 32'd4, instr_of(exp_pc[k]));
                end
                k++;
            end
            step();
        end
        if (k < 3) begin
            checks++;
            errors++;
            $display("FAIL wrap_timeout: got %0d entries, expected 3", k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_vector();
        test_backpressure();
        test_squash();
        test_redirect_rsp();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
